com_ctrl_multitask: RTL and testbench

Parametrised multi-channel task controller: each of CHANNELS independent channels tracks one accelerator task from a start pulse to a done pulse. Each channel drives a polarity-configurable `running` level, queues one start request that arrives while busy, and enforces an optional cycle timeout. It sits between the layer scheduler and the compute/DMA engines and replaces per-engine single-task controllers.

---
 rtl/com_ctrl_pkg.sv | 15 +
 rtl/com_ctrl_multitask_if.sv | 42 ++++
 rtl/com_ctrl_chan.sv | 76 +++++++
 rtl/com_ctrl_multitask.sv | 52 +++++
 tb/tb_com_ctrl_multitask.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/com_ctrl_pkg.sv
// Shared types for the multi-channel task controller.
// Channel state encoding lives here so top, channel and tools agree.
package com_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/com_ctrl_multitask_if.sv
// Scheduler-side bundle of the multi-channel task controller.
// master = scheduler/engines, slave = controller.
interface com_ctrl_multitask_if #(
  parameter int CHANNELS  = 4,
  parameter int TIMEOUT_W = 16
);
  import com_ctrl_pkg::*;

  localparam int CW = cnt_w(CHANNELS);

  logic [CHANNELS-1:0]  start_signal;
  logic [CHANNELS-1:0]  done_signal;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic [CHANNELS-1:0]  timeout_clr;
  logic [CHANNELS-1:0]  running;
  logic [CHANNELS-1:0]  finish_pulse;
  logic [CHANNELS-1:0]  timeout_flag;
  logic [CW-1:0]        busy_count;

  modport master (
    output start_signal,
    output done_signal,
    output timeout_limit,
    output timeout_clr,
    input  running,
    input  finish_pulse,
    input  timeout_flag,
    input  busy_count
  );

  modport slave (
    input  start_signal,
    input  done_signal,
    input  timeout_limit,
    input  timeout_clr,
    output running,
    output finish_pulse,
    output timeout_flag,
    output busy_count
  );

endinterface

// File: rtl/com_ctrl_chan.sv
// One task channel: FSM, depth-1 start queue, timeout counter
// and sticky timeout flag. All outputs registered from state.
module com_ctrl_chan
  import com_ctrl_pkg::*;
#(
  parameter bit POLARITY    = 1'b1,
  parameter int TIMEOUT_W   = 16,
  parameter int QUEUE_START = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done,
  input  logic                 clr,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 running,
  output logic                 finish,
  output logic                 flag,
  output logic                 is_run
);

  state_t               state;
  logic                 queued;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 hit_q;
  logic                 hit;
  logic                 qstart;

  assign is_run = (state == ST_RUN);
  assign qstart = start && (QUEUE_START != 0);
  assign hit    = is_run && (limit != '0)
               && (cnt == limit - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      queued  <= 1'b0;
      cnt     <= '0;
      hit_q   <= 1'b0;
      running <= ~POLARITY;
      finish  <= 1'b0;
      flag    <= 1'b0;
    end else begin
      running <= is_run ? POLARITY : ~POLARITY;
      finish  <= (state == ST_PEND);
      // hit_q lines the flag up with finish_pulse
      flag    <= hit_q | (flag & ~clr);
      hit_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || queued) begin
            state  <= ST_RUN;
            cnt    <= '0;
            queued <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (qstart) queued <= 1'b1;
          if (done) begin
            state <= ST_PEND;
          end else if (hit) begin
            state <= ST_PEND;
            hit_q <= 1'b1;
          end
        end
        ST_PEND: begin
          state <= ST_IDLE;
          if (qstart) queued <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/com_ctrl_multitask.sv
// Multi-channel task controller: independent channels plus a
// registered count of channels currently running.
module com_ctrl_multitask
  import com_ctrl_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter bit POLARITY    = 1'b1,
  parameter int TIMEOUT_W   = 16,
  parameter int QUEUE_START = 1
) (
  input logic                 clk,
  input logic                 rst,
  com_ctrl_multitask_if.slave bus
);

  localparam int CW = cnt_w(CHANNELS);

  logic [CHANNELS-1:0] is_run;
  logic [CW-1:0]       pop;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    com_ctrl_chan #(
      .POLARITY    (POLARITY),
      .TIMEOUT_W   (TIMEOUT_W),
      .QUEUE_START (QUEUE_START)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .start   (bus.start_signal[i]),
      .done    (bus.done_signal[i]),
      .clr     (bus.timeout_clr[i]),
      .limit   (bus.timeout_limit),
      .running (bus.running[i]),
      .finish  (bus.finish_pulse[i]),
      .flag    (bus.timeout_flag[i]),
      .is_run  (is_run[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + CW'(is_run[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.busy_count <= '0;
    else      bus.busy_count <= pop;
  end

endmodule

// File: tb/tb_com_ctrl_multitask.sv
// Random-stimulus scoreboard bench for com_ctrl_multitask.
// Task-level reference model predicts every registered output.
module tb_com_ctrl_multitask;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int CW = $clog2(N + 1);
  localparam bit POL = 1'b0;
  localparam int QS = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  com_ctrl_multitask_if #(
    .CHANNELS  (N),
    .TIMEOUT_W (TW)
  ) bus ();

  com_ctrl_multitask #(
    .CHANNELS    (N),
    .POLARITY    (POL),
    .TIMEOUT_W   (TW),
    .QUEUE_START (QS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0]  run;
    logic [N-1:0]  fin;
    logic [N-1:0]  flg;
    logic [CW-1:0] busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  // abstract per-channel task model
  bit act[N];
  bit fin_m[N];
  bit by_to[N];
  bit q_m[N];
  bit flg_m[N];
  int age[N];

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   b;
    int   lim;
    e = '0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        act[i] = 0; fin_m[i] = 0; by_to[i] = 0;
        q_m[i] = 0; flg_m[i] = 0; age[i] = 0;
      end
      e.run = {N{~POL}};
    end else begin
      b   = 0;
      lim = int'(bus.timeout_limit);
      for (int i = 0; i < N; i++) begin
        e.run[i] = act[i] ? POL : ~POL;
        e.fin[i] = fin_m[i];
        flg_m[i] = (flg_m[i] && !bus.timeout_clr[i])
                || (fin_m[i] && by_to[i]);
        e.flg[i] = flg_m[i];
        b += int'(act[i]);
      end
      e.busy = CW'(b);
      for (int i = 0; i < N; i++) begin
        bit st;
        bit dn;
        st = bus.start_signal[i];
        dn = bus.done_signal[i];
        if (fin_m[i]) begin
          fin_m[i] = 0;
          if (st && QS != 0) q_m[i] = 1;
        end else if (act[i]) begin
          age[i]++;
          if (st && QS != 0) q_m[i] = 1;
          if (dn) begin
            act[i] = 0; fin_m[i] = 1; by_to[i] = 0;
          end else if (lim != 0 && age[i] == lim) begin
            act[i] = 0; fin_m[i] = 1; by_to[i] = 1;
          end
        end else if (st || q_m[i]) begin
          act[i] = 1; age[i] = 0; q_m[i] = 0;
        end
      end
    end
    sb.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("running", int'(bus.running), int'(e.run));
      chk("finish", int'(bus.finish_pulse), int'(e.fin));
      chk("tflag", int'(bus.timeout_flag), int'(e.flg));
      chk("busy", int'(bus.busy_count), int'(e.busy));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"}, int'(bus.running), int'({N{~POL}}));
    chk({tag, "_fin"}, int'(bus.finish_pulse), 0);
    chk({tag, "_flg"}, int'(bus.timeout_flag), 0);
    chk({tag, "_busy"}, int'(bus.busy_count), 0);
  endtask

  initial begin
    bus.start_signal  = '0;
    bus.done_signal   = '0;
    bus.timeout_clr   = '0;
    bus.timeout_limit = TW'(8);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_init");
    rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc % 1000 == 999) begin
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
      if (cyc % 250 == 0)
        bus.timeout_limit = TW'($urandom_range(0, 12));
      for (int i = 0; i < N; i++) begin
        bus.start_signal[i] = ($urandom_range(0, 5) == 0);
        bus.done_signal[i]  = ($urandom_range(0, 9) == 0);
        bus.timeout_clr[i]  = ($urandom_range(0, 15) == 0);
      end
    end
    @(negedge clk);
    bus.start_signal = '0;
    bus.done_signal  = '0;
    bus.timeout_clr  = '0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
